// File: rtl/vga_sync_decoder.sv
// VGA sync receiver: recovers pixel coordinates and data-enable from active-low hsync/vsync,
// measures line length and frame height, and locks after repeated identical clean frames.
module vga_sync_decoder #(
  parameter int H_ACT_START = 256,
  parameter int H_ACT_LEN   = 800,
  parameter int V_ACT_START = 27,
  parameter int V_ACT_LEN   = 600,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic [9:0]  pixh,
  output logic [9:0]  pixv,
  output logic        de,
  output logic        locked,
  output logic [10:0] line_len,
  output logic [9:0]  frame_lines
);

  localparam logic [10:0] H_SAT  = 11'h7FF;
  localparam logic [10:0] H_LO   = 11'(H_ACT_START);
  localparam logic [10:0] H_HI   = 11'(H_ACT_START + H_ACT_LEN);
  localparam logic [9:0]  V_LO   = 10'(V_ACT_START);
  localparam logic [9:0]  V_HI   = 10'(V_ACT_START + V_ACT_LEN);
  localparam logic [2:0]  LOCK_N = 3'(LOCK_FRAMES);

  typedef enum logic [1:0] {S_SEARCH, S_MEASURE, S_LOCKED} state_t;

  logic hs_meta_q, hs_sync_q, hs_prev_q;
  logic vs_meta_q, vs_sync_q, vs_prev_q;

  state_t      state_q, state_d;
  logic [10:0] hcnt_q, hcnt_d;
  logic [9:0]  vcnt_q, vcnt_d;
  logic [10:0] ref_len_q, ref_len_d;
  logic        have_ref_q, have_ref_d;
  logic        dirty_q, dirty_d;
  logic [10:0] prev_len_q, prev_len_d;
  logic [9:0]  prev_lines_q, prev_lines_d;
  logic        prev_valid_q, prev_valid_d;
  logic [2:0]  good_cnt_q, good_cnt_d;
  logic        locked_q, locked_d;
  logic [10:0] line_len_q, line_len_d;
  logic [9:0]  frame_lines_q, frame_lines_d;
  logic        de_q, de_d;
  logic [9:0]  pixh_q, pixh_d;
  logic [9:0]  pixv_q, pixv_d;

  logic        hs_fall, vs_fall, loss, in_h, in_v;
  logic [10:0] cur_len;
  logic [9:0]  cur_lines;
  logic [10:0] rec_ref;
  logic        rec_have, rec_dirty, frame_clean, pair_match;
  logic [2:0]  good_next;

  assign hs_fall   = !hs_sync_q && hs_prev_q;
  assign vs_fall   = !vs_sync_q && vs_prev_q;
  assign cur_len   = hcnt_q + 11'd1;
  assign cur_lines = vcnt_q + 10'd1;
  assign in_h      = (hcnt_q >= H_LO) && (hcnt_q < H_HI);
  assign in_v      = (vcnt_q >= V_LO) && (vcnt_q < V_HI);
  assign loss      = (hs_fall && (cur_len != line_len_q)) ||
                     (vs_fall && (cur_lines != frame_lines_q)) ||
                     (hcnt_q == H_SAT);

  always_comb begin
    state_d       = state_q;
    ref_len_d     = ref_len_q;
    have_ref_d    = have_ref_q;
    dirty_d       = dirty_q;
    prev_len_d    = prev_len_q;
    prev_lines_d  = prev_lines_q;
    prev_valid_d  = prev_valid_q;
    good_cnt_d    = good_cnt_q;
    locked_d      = locked_q;
    line_len_d    = line_len_q;
    frame_lines_d = frame_lines_q;
    pixh_d        = pixh_q;
    pixv_d        = pixv_q;
    good_next     = good_cnt_q;

    hcnt_d = hs_fall ? 11'd0 : ((hcnt_q == H_SAT) ? hcnt_q : hcnt_q + 11'd1);
    vcnt_d = vs_fall ? 10'd0 : (hs_fall ? vcnt_q + 10'd1 : vcnt_q);

    // Frame record including the line that ends this cycle, so a coincident
    // vsync fall closes the frame with its final line accounted for.
    rec_ref   = ref_len_q;
    rec_have  = have_ref_q;
    rec_dirty = dirty_q || (hcnt_q == H_SAT);
    if (hs_fall) begin
      if (!have_ref_q) begin
        rec_ref  = cur_len;
        rec_have = 1'b1;
      end else if (cur_len != ref_len_q) begin
        rec_dirty = 1'b1;
      end
    end
    frame_clean = rec_have && !rec_dirty;
    pair_match  = prev_valid_q && (rec_ref == prev_len_q) && (cur_lines == prev_lines_q);

    case (state_q)
      S_SEARCH: begin
        if (vs_fall) begin
          state_d      = S_MEASURE;
          have_ref_d   = 1'b0;
          dirty_d      = 1'b0;
          prev_valid_d = 1'b0;
          good_cnt_d   = 3'd0;
        end
      end
      S_MEASURE: begin
        ref_len_d  = rec_ref;
        have_ref_d = rec_have;
        dirty_d    = rec_dirty;
        if (vs_fall) begin
          if (!frame_clean)    good_next = 3'd0;
          else if (pair_match) good_next = good_cnt_q + 3'd1;
          else                 good_next = 3'd1;
          good_cnt_d   = good_next;
          prev_len_d   = rec_ref;
          prev_lines_d = cur_lines;
          prev_valid_d = frame_clean;
          have_ref_d   = 1'b0;
          dirty_d      = 1'b0;
          if (good_next == LOCK_N) begin
            state_d       = S_LOCKED;
            locked_d      = 1'b1;
            line_len_d    = rec_ref;
            frame_lines_d = cur_lines;
          end
        end
      end
      S_LOCKED: begin
        if (loss) begin
          state_d  = S_SEARCH;
          locked_d = 1'b0;
        end
      end
      default: state_d = S_SEARCH;
    endcase

    de_d = (state_q == S_LOCKED) && !loss && in_h && in_v;
    if (de_d) begin
      pixh_d = 10'(hcnt_q - H_LO);
      pixv_d = vcnt_q - V_LO;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      hs_meta_q     <= 1'b1;
      hs_sync_q     <= 1'b1;
      hs_prev_q     <= 1'b1;
      vs_meta_q     <= 1'b1;
      vs_sync_q     <= 1'b1;
      vs_prev_q     <= 1'b1;
      state_q       <= S_SEARCH;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      ref_len_q     <= '0;
      have_ref_q    <= 1'b0;
      dirty_q       <= 1'b0;
      prev_len_q    <= '0;
      prev_lines_q  <= '0;
      prev_valid_q  <= 1'b0;
      good_cnt_q    <= '0;
      locked_q      <= 1'b0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
      de_q          <= 1'b0;
      pixh_q        <= '0;
      pixv_q        <= '0;
    end else begin
      hs_meta_q     <= hsync_in;
      hs_sync_q     <= hs_meta_q;
      hs_prev_q     <= hs_sync_q;
      vs_meta_q     <= vsync_in;
      vs_sync_q     <= vs_meta_q;
      vs_prev_q     <= vs_sync_q;
      state_q       <= state_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      ref_len_q     <= ref_len_d;
      have_ref_q    <= have_ref_d;
      dirty_q       <= dirty_d;
      prev_len_q    <= prev_len_d;
      prev_lines_q  <= prev_lines_d;
      prev_valid_q  <= prev_valid_d;
      good_cnt_q    <= good_cnt_d;
      locked_q      <= locked_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      de_q          <= de_d;
      pixh_q        <= pixh_d;
      pixv_q        <= pixv_d;
    end
  end

  assign pixh        = pixh_q;
  assign pixv        = pixv_q;
  assign de          = de_q;
  assign locked      = locked_q;
  assign line_len    = line_len_q;
  assign frame_lines = frame_lines_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder using a scaled-down raster (40 clk/line, 12 lines/frame)
// so that every scenario completes in a few thousand clocks.
module tb_vga_sync_decoder;
  localparam int HS = 8, HL = 24, VS = 3, VL = 6;
  localparam int LINE = 40, HSW = 4, FRAME = 12, VSW = 2;

  logic        clk = 1'b0;
  logic        clr, hsync_in, vsync_in;
  logic [9:0]  pixh, pixv, frame_lines;
  logic        de, locked;
  logic [10:0] line_len;

  vga_sync_decoder #(
    .H_ACT_START(HS), .H_ACT_LEN(HL), .V_ACT_START(VS), .V_ACT_LEN(VL), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .clr(clr), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .pixh(pixh), .pixv(pixv), .de(de), .locked(locked),
    .line_len(line_len), .frame_lines(frame_lines)
  );

  always #5 clk = ~clk;

  int cyc = 0, gen_h = 0, gen_l = 0, cur_line, cur_frame;
  bit gen_on = 0, hold_high = 0, short_en = 0, alt_mode = 0, alt_phase = 0;
  int vfall_count = 0, vfall_k = 0, hfall_k = 0, hfall_line = -1;
  int checks = 0, errors = 0;

  // Raster generator: drives just after each posedge; a value driven after posedge c
  // is first sampled by the DUT at posedge c+1, which is recorded as the fall time.
  initial begin
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (gen_on) begin
        cur_line  = (short_en && gen_l == 5) ? 30 : LINE;
        cur_frame = alt_mode ? (alt_phase ? 14 : 12) : FRAME;
        hsync_in  = hold_high || !(gen_h < HSW);
        vsync_in  = hold_high || !(gen_l < VSW);
        if (!hold_high && gen_h == 0) begin
          hfall_k    = cyc + 1;
          hfall_line = gen_l;
          if (gen_l == 0) begin
            vfall_k = cyc + 1;
            vfall_count++;
          end
        end
        gen_h++;
        if (gen_h >= cur_line) begin
          gen_h = 0;
          if (short_en && gen_l == 5) short_en = 0;
          gen_l++;
          if (gen_l >= cur_frame) begin
            gen_l = 0;
            alt_phase = !alt_phase;
          end
        end
      end
    end
  end

  task automatic to_cyc(input int n);
    if (cyc > n) begin
      errors++;
      $display("FAIL to_cyc: already at cycle %0d, wanted %0d", cyc, n);
    end
    while (cyc < n) @(negedge clk);
  endtask

  task automatic wait_hfall(input int line, output int k);
    int t = 0;
    @(negedge clk);
    while (!(hfall_line == line && hfall_k == cyc + 1) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) begin
      checks++; errors++;
      $display("FAIL wait_hfall line %0d: timeout", line);
    end
    k = hfall_k;
  endtask

  task automatic wait_pos(input int l, input int h);
    int t = 0;
    while (!(gen_l == l && gen_h == h) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) begin
      checks++; errors++;
      $display("FAIL wait_pos %0d/%0d: timeout", l, h);
    end
  endtask

  task automatic expect_lock(input int n, input string name);
    int base = vfall_count;
    int t = 0;
    int k;
    bit noisy = 0;
    while (vfall_count < base + n && t < 20000) begin
      @(negedge clk);
      t++;
      if (locked || de) noisy = 1;
    end
    checks++;
    if (t >= 20000) begin errors++; $display("FAIL %s timeout: got %0d vsync falls, expected %0d", name, vfall_count - base, n); end
    k = vfall_k;
    to_cyc(k + 1);
    if (locked || de) noisy = 1;
    checks++;
    if (noisy) begin errors++; $display("FAIL %s early: got locked/de high before fall %0d, expected low", name, n); end
    to_cyc(k + 2);
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL %s locked: got %b expected 1", name, locked); end
    checks++;
    if (line_len !== 11'd40) begin errors++; $display("FAIL %s line_len: got %0d expected 40", name, line_len); end
    checks++;
    if (frame_lines !== 10'd12) begin errors++; $display("FAIL %s frame_lines: got %0d expected 12", name, frame_lines); end
    $display("lock %s: locked at cycle %0d, line_len=%0d frame_lines=%0d", name, cyc, line_len, frame_lines);
  endtask

  task automatic check_zero_outputs(input string name);
    checks++;
    if ({pixh, pixv, de, locked, line_len, frame_lines} !== '0) begin
      errors++;
      $display("FAIL %s: got pixh=%0d pixv=%0d de=%b locked=%b line_len=%0d frame_lines=%0d, expected all 0",
               name, pixh, pixv, de, locked, line_len, frame_lines);
    end
  endtask

  task automatic test_reset();
    clr = 1'b1;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset_during");
    clr = 1'b0;
    @(negedge clk);
    check_zero_outputs("reset_after");
    $display("reset: outputs after clr pixh=%0d pixv=%0d de=%b locked=%b", pixh, pixv, de, locked);
    gen_on = 1'b1;
  endtask

  task automatic test_lock();
    expect_lock(3, "initial");
  endtask

  task automatic test_pixels();
    int k;
    wait_hfall(2, k);
    to_cyc(k + 11);
    checks++; if (de !== 1'b0) begin errors++; $display("FAIL line2_de: got %b expected 0", de); end
    wait_hfall(3, k);
    to_cyc(k + 10);
    checks++; if (de !== 1'b0) begin errors++; $display("FAIL de_before_first: got %b expected 0", de); end
    to_cyc(k + 11);
    checks++; if ({de, pixh, pixv} !== {1'b1, 10'd0, 10'd0}) begin errors++; $display("FAIL first_pixel: got de=%b pixh=%0d pixv=%0d expected 1/0/0", de, pixh, pixv); end
    to_cyc(k + 16);
    checks++; if (pixh !== 10'd5) begin errors++; $display("FAIL pixh_mid: got %0d expected 5", pixh); end
    to_cyc(k + 34);
    checks++; if ({de, pixh} !== {1'b1, 10'd23}) begin errors++; $display("FAIL last_pixel: got de=%b pixh=%0d expected 1/23", de, pixh); end
    to_cyc(k + 35);
    checks++; if ({de, pixh} !== {1'b0, 10'd23}) begin errors++; $display("FAIL de_fall_hold: got de=%b pixh=%0d expected 0/23", de, pixh); end
    $display("pixels: line 3 active window checked from cycle %0d", k);
    wait_hfall(8, k);
    to_cyc(k + 11);
    checks++; if ({de, pixh, pixv} !== {1'b1, 10'd0, 10'd5}) begin errors++; $display("FAIL last_line: got de=%b pixh=%0d pixv=%0d expected 1/0/5", de, pixh, pixv); end
    wait_hfall(9, k);
    to_cyc(k + 11);
    checks++; if ({de, pixv} !== {1'b0, 10'd5}) begin errors++; $display("FAIL after_last_line: got de=%b pixv=%0d expected 0/5", de, pixv); end
    $display("pixels: last active line pixv=%0d", pixv);
  endtask

  task automatic test_short_line();
    int k;
    wait_hfall(1, k);
    short_en = 1'b1;
    wait_hfall(6, k);
    to_cyc(k + 1);
    checks++; if ({locked, de, pixh} !== {1'b1, 1'b1, 10'd20}) begin errors++; $display("FAIL short_before: got locked=%b de=%b pixh=%0d expected 1/1/20", locked, de, pixh); end
    to_cyc(k + 2);
    checks++; if ({locked, de} !== 2'b00) begin errors++; $display("FAIL short_loss: got locked=%b de=%b expected 0/0", locked, de); end
    checks++; if ({line_len, frame_lines} !== {11'd40, 10'd12}) begin errors++; $display("FAIL short_hold: got line_len=%0d frame_lines=%0d expected 40/12", line_len, frame_lines); end
    $display("short_line: lock lost at cycle %0d", cyc);
    expect_lock(3, "after_short_line");
  endtask

  task automatic test_sync_loss();
    int k;
    wait_hfall(4, k);
    hold_high = 1'b1;
    to_cyc(k + 2049);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL sat_before: got locked=%b expected 1", locked); end
    to_cyc(k + 2050);
    checks++; if ({locked, de} !== 2'b00) begin errors++; $display("FAIL sat_loss: got locked=%b de=%b expected 0/0", locked, de); end
    $display("sync_loss: lock dropped at cycle %0d", cyc);
    wait_pos(5, 10);
    hold_high = 1'b0;
    expect_lock(3, "after_sync_loss");
  endtask

  task automatic test_clr_mid_line();
    int k;
    wait_hfall(4, k);
    to_cyc(k + 20);
    checks++; if (de !== 1'b1) begin errors++; $display("FAIL clr_pre_de: got %b expected 1", de); end
    clr = 1'b1;
    to_cyc(k + 21);
    check_zero_outputs("clr_mid_line");
    clr = 1'b0;
    $display("clr_mid_line: reset applied at cycle %0d", cyc);
    expect_lock(3, "after_clr");
  endtask

  task automatic test_alternating();
    int base, t;
    bit seen;
    wait_pos(5, 0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    alt_phase = 1'b0;
    alt_mode  = 1'b1;
    base = vfall_count;
    t = 0;
    seen = 0;
    while (vfall_count < base + 8 && t < 20000) begin
      @(negedge clk);
      t++;
      if (locked || de) seen = 1;
    end
    repeat (4) @(negedge clk);
    if (locked || de) seen = 1;
    checks++; if (t >= 20000) begin errors++; $display("FAIL alt_timeout: got %0d vsync falls expected 8", vfall_count - base); end
    checks++; if (seen) begin errors++; $display("FAIL alt_never_lock: got locked/de high, expected never"); end
    checks++; if ({frame_lines, line_len} !== '0) begin errors++; $display("FAIL alt_measure: got frame_lines=%0d line_len=%0d expected 0/0", frame_lines, line_len); end
    $display("alternating: %0d frames, locked=%b frame_lines=%0d", vfall_count - base, locked, frame_lines);
  endtask

  initial begin
    clr = 1'b1;
    test_reset();
    test_lock();
    test_pixels();
    test_short_line();
    test_sync_loss();
    test_clr_mid_line();
    test_alternating();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
